pr_bus_arbiter: RTL
===================

Name: pr_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the peripheral (PR) bus that feeds the bridge and the TC1/TC2 timers.
- Master 0 is the CPU PR port; master 1 is a secondary requester (debug/DMA).
- Round-robin grant; runs one registered transaction at a time. Illegal addresses are blocked before they reach the bridge.
- Sits between the masters and the bridge's pr_a/pr_we/pr_wd/pr_rd.

Parameters:
- TC1_BASE, 32'h0000_7F00, byte base of TC1 window
- TC2_BASE, 32'h0000_7F10, byte base of TC2 window
- WIN_BYTES, 12, size of each window in bytes (3 word registers)
- LOCK_MAX, 4, max consecutive locked grants to one master (used only with PR_LOCK_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  transaction request; held high until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_lock / m1_lock  in  1  keep-bus hint (PR_LOCK_EN only; otherwise unused)
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid while ack is high
- m0_err / m1_err  out  1  illegal-address flag, valid while ack is high
- pr_a  out  32  bus address to bridge
- pr_we  out  1  bus write enable
- pr_wd  out  32  bus write data
- pr_rd  in  32  combinational read data from bridge
- busy  out  1  high in ADDR or DATA state

Behaviour:
- Reset (async): state=IDLE; last_grant=1, so m0 wins the first tie.
- Also at reset: all ack/err/pr_we/busy = 0; pr_a, pr_wd and rdata = 0; lock counter = 0.
- Reset asserted mid-transaction aborts it. No ack is issued and pr_we drops immediately.
- FSM states are IDLE, ADDR and DATA.
- IDLE: if any req is high at the clock edge, pick the winner and go to ADDR.
  - Only one requester: grant it.
  - Both requesting: grant the master that is not last_grant.
  - Update last_grant; register the winner's we/addr/wdata.
- ADDR (1 cycle):
  - Drive pr_a = latched addr and pr_wd = latched wdata.
  - pr_we = latched we AND legal.
  - Sample pr_rd at the end of the cycle. Next state is DATA.
- Legal address: word aligned (addr[1:0]==0) and inside [TC1_BASE, TC1_BASE+WIN_BYTES) or [TC2_BASE, TC2_BASE+WIN_BYTES).
- Illegal address: pr_we forced 0, rdata returned 0, err=1.
- DATA (1 cycle):
  - Pulse ack of the granted master with rdata (reads; 0 for writes) and err.
  - pr_we=0 and pr_a holds its value.
  - Arbitrate on the reqs seen this cycle, going to ADDR if any, else IDLE.
- Ack cycle: the master must drop req unless it wants a new transaction. A req high during ack counts as a new request.
- Throughput: 1 transaction per 2 cycles. Latency from req sampled to ack is 2 cycles.
- The non-granted master's ack/rdata/err stay 0.
- Its req is never dropped by the arbiter; it waits at most one transaction without lock.
- Payload changes after grant are ignored until ack.

Optional Feature:
- Macro: PR_LOCK_EN.
- With it: if the granted master has lock=1 and req=1 in DATA, it is regranted regardless of round-robin.
  - A lock counter increments on each regrant.
  - Once the count reaches LOCK_MAX, the other master wins if requesting, and the counter clears.
  - The counter also clears on any grant change or in IDLE.
- Without it: lock inputs are ignored and arbitration is strict round-robin.

Test Plan:
- Single read: m0 reads 32'h7F04 while the bridge returns 32'h0000_00A5 → pr_a=32'h7F04 in ADDR; m0_ack pulses 2 cycles after req is sampled with m0_rdata=32'h0000_00A5 and err=0.
- Single write: m1 writes 32'h7F10 with data 32'h1234 → pr_we=1 for exactly 1 cycle with pr_wd=32'h1234; m1_ack follows 1 cycle later.
- Contention: both masters hold req continuously → grants alternate m0, m1, m0, m1, and acks land on cycles 2, 4, 6, 8 after start.
- Illegal: m0 writes 32'h7F0C, then 32'h7F12 → pr_we stays 0; m0_ack with err=1 and rdata=0 for both.
- Reset in ADDR of a write → pr_we=0 immediately and no ack; after release, m0 wins the next tie.
- PR_LOCK_EN with LOCK_MAX=4: m0 locked and requesting, m1 requesting → m0 granted 5 times consecutively (initial + 4 regrants), then m1 is granted.

Source files
------------

// File: rtl/pr_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// pr_bus_arbiter_if
// Bundles the two requester ports and the bridge-side PR bus of the
// peripheral-bus arbiter.
//   m0_* / m1_* : req/we/addr/wdata/lock from each master; ack/rdata/err back
//   pr_a/pr_we/pr_wd : bus address, write enable and write data to the bridge
//   pr_rd            : combinational read data returned by the bridge
// Modports:
//   slave  - the arbiter side (serves the masters, drives the bridge)
//   master - the requester/bridge-model side
// ---------------------------------------------------------------------------
interface pr_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_lock;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_lock;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [31:0] pr_a;
  logic        pr_we;
  logic [31:0] pr_wd;
  logic [31:0] pr_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  pr_rd,
    output m0_ack, m0_rdata, m0_err,
    output m1_ack, m1_rdata, m1_err,
    output pr_a, pr_we, pr_wd
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output pr_rd,
    input  m0_ack, m0_rdata, m0_err,
    input  m1_ack, m1_rdata, m1_err,
    input  pr_a, pr_we, pr_wd
  );
endinterface

// File: rtl/pr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pr_bus_arbiter
// Two-master round-robin arbiter/sequencer for the PR bus feeding the bridge
// and the TC1/TC2 timer windows. One transaction at a time:
//   IDLE -> ADDR (bus driven, pr_rd sampled) -> DATA (ack pulse) -> ...
// Accesses outside the two word-aligned timer windows never assert pr_we,
// return rdata=0 and flag err.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - pr_bus_arbiter_if.slave (both masters + bridge PR bus)
//   busy  - high while in ADDR or DATA
// Optional feature macro: PR_LOCK_EN
//   defined   : a granted master holding lock+req is regranted up to
//               LOCK_MAX extra times before the other master gets a turn
//   undefined : lock inputs ignored, strict round-robin
// ---------------------------------------------------------------------------
module pr_bus_arbiter #(
  parameter logic [31:0] TC1_BASE  = 32'h0000_7F00,
  parameter logic [31:0] TC2_BASE  = 32'h0000_7F10,
  parameter logic [31:0] WIN_BYTES = 32'd12,
  parameter int unsigned LOCK_MAX  = 4
) (
  input  logic            clk,
  input  logic            reset,
  pr_bus_arbiter_if.slave bus,
  output logic            busy
);

  localparam int unsigned     LCW        = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0]  LOCK_MAX_C = LCW'(LOCK_MAX);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, next_state;
  logic        last_grant;   // master granted most recently
  logic        gnt;          // master owning the current transaction
  logic        lat_we;
  logic        lat_legal;

  logic        arb_any;
  logic        arb_pick;
  logic        grant_fire;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_legal;
  logic [31:0] rd_val;

  function automatic logic addr_legal(input logic [31:0] a);
    logic in_tc1;
    logic in_tc2;
    in_tc1 = (a >= TC1_BASE) && (a < TC1_BASE + WIN_BYTES);
    in_tc2 = (a >= TC2_BASE) && (a < TC2_BASE + WIN_BYTES);
    return (a[1:0] == 2'b00) && (in_tc1 || in_tc2);
  endfunction

`ifdef PR_LOCK_EN
  logic [LCW-1:0] lock_cnt;
  logic           regrant;
  logic           gnt_req;
  logic           gnt_lock;

  assign gnt_req  = gnt ? bus.m1_req  : bus.m0_req;
  assign gnt_lock = gnt ? bus.m1_lock : bus.m0_lock;
`else
  logic unused_lock;
  assign unused_lock = ^{bus.m0_lock, bus.m1_lock, LOCK_MAX_C};
`endif

  // Arbitration: a lone requester wins; on a tie the master that was not
  // granted last wins. With locking, the current owner may keep the bus.
  always_comb begin
    arb_any = bus.m0_req | bus.m1_req;
    if (bus.m0_req && bus.m1_req) arb_pick = ~last_grant;
    else                          arb_pick = bus.m1_req;
`ifdef PR_LOCK_EN
    regrant = 1'b0;
    if ((state == DATA) && gnt_lock && gnt_req && (lock_cnt < LOCK_MAX_C)) begin
      arb_pick = gnt;
      regrant  = 1'b1;
    end
`endif
  end

  assign win_we    = arb_pick ? bus.m1_we    : bus.m0_we;
  assign win_addr  = arb_pick ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata = arb_pick ? bus.m1_wdata : bus.m0_wdata;
  assign win_legal = addr_legal(win_addr);

  // Writes and illegal accesses return zero instead of the bridge data.
  assign rd_val = (lat_we || !lat_legal) ? 32'd0 : bus.pr_rd;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (arb_any) next_state = ADDR;
      ADDR:    next_state = DATA;
      DATA:    next_state = arb_any ? ADDR : IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign grant_fire = (next_state == ADDR);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Grant stage: latch winner's payload onto the bus registers.
  // Address stage end: capture read data into the granted master's ack regs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= 1'b1;
      gnt          <= 1'b0;
      lat_we       <= 1'b0;
      lat_legal    <= 1'b0;
      bus.pr_a     <= '0;
      bus.pr_we    <= 1'b0;
      bus.pr_wd    <= '0;
      bus.m0_ack   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m0_err   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m1_rdata <= '0;
      bus.m1_err   <= 1'b0;
    end else begin
      bus.pr_we    <= 1'b0;
      bus.m0_ack   <= 1'b0;
      bus.m0_rdata <= '0;
      bus.m0_err   <= 1'b0;
      bus.m1_ack   <= 1'b0;
      bus.m1_rdata <= '0;
      bus.m1_err   <= 1'b0;

      if (state == ADDR) begin
        if (gnt) begin
          bus.m1_ack   <= 1'b1;
          bus.m1_rdata <= rd_val;
          bus.m1_err   <= ~lat_legal;
        end else begin
          bus.m0_ack   <= 1'b1;
          bus.m0_rdata <= rd_val;
          bus.m0_err   <= ~lat_legal;
        end
      end

      if (grant_fire) begin
        last_grant <= arb_pick;
        gnt        <= arb_pick;
        lat_we     <= win_we;
        lat_legal  <= win_legal;
        bus.pr_a   <= win_addr;
        bus.pr_wd  <= win_wdata;
        bus.pr_we  <= win_we & win_legal;
      end
    end
  end

`ifdef PR_LOCK_EN
  // Counts consecutive lock regrants; any other grant or IDLE clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                lock_cnt <= '0;
    else if (grant_fire)      lock_cnt <= regrant ? lock_cnt + LCW'(1) : '0;
    else if (state == IDLE)   lock_cnt <= '0;
  end
`endif

endmodule
